// File: rtl/cond_logic.sv
// cond_logic: ARM-style condition check with split NZ/CV flag registers
module cond_logic (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Valid,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);
    logic [1:0] nz;
    logic [1:0] cv;
    logic       n, z, c, v;
    logic       pass;

    assign Flags      = {nz, cv};
    assign {n, z, c, v} = Flags;
    assign CondEx     = Valid & pass;
    assign PCSrc      = PCS & CondEx;
    assign RegWrite   = RegW & CondEx;
    assign MemWrite   = MemW & CondEx;

    // decode the condition field against the registered flags only
    always_comb begin
        pass = 1'b1;
        case (Cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = n == v;
            4'b1011: pass = n != v;
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

    // each flag half loads only when its write request and the condition both hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nz <= 2'b00;
            cv <= 2'b00;
        end else begin
            if (FlagW[1] & CondEx) nz <= ALUFlags[3:2];
            if (FlagW[0] & CondEx) cv <= ALUFlags[1:0];
        end
    end
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed self-checking bench for cond_logic
module tb_cond_logic;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       Valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
    int         errors = 0;
    int         checks = 0;

    cond_logic dut (
        .clk(clk), .reset_n(reset_n), .Valid(Valid), .Cond(Cond),
        .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Flags(Flags)
    );

    always #5 clk = ~clk;

    // reference condition table, written straight from the architecture definition
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        Valid = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
        tick();
        FlagW = 2'b00;
    endtask

    initial begin
        reset_n = 1'b0; Valid = 1'b0; Cond = 4'h0; ALUFlags = 4'h0;
        FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
        #1;
        check("reset_flags", Flags, 4'h0);
        Valid = 1'b1; Cond = 4'h1; #1;
        check("reset_condex_ne", {3'b0, CondEx}, 4'h1);
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hF;
        tick();
        check("reset_hold", Flags, 4'h0);
        @(negedge clk);
        reset_n = 1'b1; FlagW = 2'b00; RegW = 1'b1;
        Cond = 4'h0; #1;
        check("eq_condex", {3'b0, CondEx}, 4'h0);
        check("eq_regwrite", {3'b0, RegWrite}, 4'h0);
        Cond = 4'h1; #1;
        check("ne_condex", {3'b0, CondEx}, 4'h1);
        check("ne_regwrite", {3'b0, RegWrite}, 4'h1);
        Cond = 4'hE; ALUFlags = 4'hF;
        tick();
        check("first_edge_noflag", Flags, 4'h0);
        RegW = 1'b0;
        Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'h6; #1;
        check("aluflags_no_bypass", {3'b0, CondEx}, 4'h0);
        Cond = 4'hE;
        tick();
        check("write_all", Flags, 4'h6);
        FlagW = 2'b00;
        Cond = 4'h0; #1;
        check("eq_after_write", {3'b0, CondEx}, 4'h1);
        Cond = 4'h8; #1;
        check("hi_after_write", {3'b0, CondEx}, 4'h0);
        Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'h9;
        tick();
        check("write_nz_only", Flags, 4'hA);
        FlagW = 2'b01; ALUFlags = 4'h5;
        tick();
        check("write_cv_only", Flags, 4'h9);
        FlagW = 2'b00; Cond = 4'hA; #1;
        check("ge_back_to_back", {3'b0, CondEx}, 4'h1);
        load_flags(4'h0);
        check("clear_flags", Flags, 4'h0);
        Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'hF; MemW = 1'b1; #1;
        check("failed_memwrite", {3'b0, MemWrite}, 4'h0);
        tick();
        check("failed_no_update", Flags, 4'h0);
        Cond = 4'h1; FlagW = 2'b00; #1;
        check("pass_memwrite", {3'b0, MemWrite}, 4'h1);
        MemW = 1'b0;
        Valid = 1'b0; Cond = 4'hE; FlagW = 2'b11; PCS = 1'b1; ALUFlags = 4'hF; #1;
        check("bubble_pcsrc", {3'b0, PCSrc}, 4'h0);
        check("bubble_condex", {3'b0, CondEx}, 4'h0);
        tick();
        check("bubble_no_update", Flags, 4'h0);
        Valid = 1'b1; FlagW = 2'b00; #1;
        check("valid_pcsrc", {3'b0, PCSrc}, 4'h1);
        PCS = 1'b0;
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            check("sweep_load", Flags, 4'(f));
            for (int c = 0; c < 16; c++) begin
                Cond = 4'(c); #1;
                check($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, CondEx},
                      {3'b0, ref_cond(4'(c), 4'(f))});
            end
            Valid = 1'b0; Cond = 4'hE; #1;
            check("sweep_invalid", {3'b0, CondEx}, 4'h0);
            Valid = 1'b1;
        end
        load_flags(4'hF);
        check("set_all", Flags, 4'hF);
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'hA;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", Flags, 4'h0);
        tick();
        check("reset_cancels_write", Flags, 4'h0);
        @(negedge clk);
        reset_n = 1'b1; FlagW = 2'b00;
        tick();
        check("after_release", Flags, 4'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 SHALL provide port: clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 SHALL provide port: reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: Valid  input  1  current instruction is valid; 0 means a stall or bubble.
REQ-005 SHALL provide port: Cond  input  4  instruction condition field [31:28].
REQ-006 SHALL provide port: ALUFlags  input  4  ALU result flags {N,Z,C,V}, bit 3 = N.
REQ-007 SHALL provide port: FlagW  input  2  flag-write request from the ALU decoder; bit1 = {N,Z}, bit0 = {C,V}.
REQ-008 SHALL provide port: PCS  input  1  unconditioned PC-write request.
REQ-009 SHALL provide port: RegW  input  1  unconditioned register-write request.
REQ-010 SHALL provide port: MemW  input  1  unconditioned memory-write request.
REQ-011 SHALL provide port: PCSrc  output  1  conditioned PC write.
REQ-012 SHALL provide port: RegWrite  output  1  conditioned register write.
REQ-013 SHALL provide port: MemWrite  output  1  conditioned memory write.
REQ-014 SHALL provide port: CondEx  output  1  condition passed for the current instruction.
REQ-015 SHALL provide port: Flags  output  4  architectural {N,Z,C,V} register.

Function
REQ-016 SHALL hold two flag registers: NZ[1:0] and CV[1:0]; Flags = {NZ,CV}.
REQ-017 SHALL compute CondEx combinationally from Cond and the registered Flags only; ALUFlags of the current cycle SHALL NOT affect CondEx in that cycle.
REQ-018 SHALL decode Cond as follows: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-019 SHALL decode Cond as follows: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1 (unconditional).
REQ-020 SHALL gate CondEx with Valid; CondEx = 0 whenever Valid = 0.
REQ-021 SHALL drive PCSrc = PCS&CondEx, RegWrite = RegW&CondEx and MemWrite = MemW&CondEx, combinationally with zero-cycle latency.
REQ-022 SHALL load NZ <= ALUFlags[3:2] at the rising edge when FlagW[1]&CondEx.
REQ-023 SHALL load CV <= ALUFlags[1:0] at the rising edge when FlagW[0]&CondEx.
REQ-024 SHALL update the two halves independently; FlagW = 10 SHALL preserve C and V, and FlagW = 01 SHALL preserve N and Z.
REQ-025 SHALL hold both flag registers unchanged on a failed condition, when Valid = 0, or when FlagW = 00.
REQ-026 SHALL make updated flags visible to CondEx in the cycle after the write edge (one-cycle latency), so back-to-back dependent instructions see the new flags.
REQ-027 SHALL treat X-free inputs only; no internal state SHALL exist beyond the 4 flag bits.

Reset
REQ-028 SHALL clear Flags to 0000 immediately on reset_n = 0, independent of clk.
REQ-029 SHALL hold Flags at 0000 while reset_n = 0; CondEx SHALL still follow REQ-017 to REQ-020 on the zero flags.
REQ-030 SHALL not update flags on the first rising edge after reset_n deasserts unless the write conditions of REQ-022 or REQ-023 hold at that edge.
REQ-031 SHALL cancel any pending flag write when reset asserts in the middle of a cycle; after release, Flags SHALL read 0000.

Verification
REQ-032 SHALL verify the following scenario: after reset, Cond = 0000 (EQ), Valid = 1, RegW = 1 -> CondEx = 0 and RegWrite = 0; Cond = 0001 (NE) -> CondEx = 1 and RegWrite = 1.
REQ-033 SHALL verify the following scenario: Cond = 1110, FlagW = 11, ALUFlags = 0110, edge -> Flags = 0110; next cycle Cond = 0000 -> CondEx = 1, and Cond = 1000 (HI) -> CondEx = 0.
REQ-034 SHALL verify the following scenario: Flags = 0110, FlagW = 10, ALUFlags = 1001, edge -> Flags = 1010 (N,Z updated; C,V kept).
REQ-035 SHALL verify the following scenario: Flags = 0000, Cond = 0000 (fails), FlagW = 11, ALUFlags = 1111, MemW = 1 -> MemWrite = 0 and Flags remain 0000 after the edge.
REQ-036 SHALL verify the following scenario: Valid = 0, Cond = 1110, FlagW = 11, PCS = 1 -> PCSrc = 0 and Flags unchanged; sweep all 16 Cond codes against all 16 Flags values and check against the table in REQ-018 and REQ-019.
REQ-037 SHALL verify the following scenario: Flags = 1111, assert reset_n = 0 between clock edges -> Flags = 0000 before the next edge.
